// File: rtl/counter_pkg.sv
// Shared types and default constants for the push-button counters.
// Reused by both the up counter and the down counter.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT
    } deb_state_t;

    localparam int CNT_WIDTH = 4;
    localparam int CLK_DIV   = 100000;
    localparam int DEB_TICKS = 20;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser, debounce prescaler and press/release qualification FSM.
// Emits a single registered Step pulse per qualified press.
module btn_debounce
    import counter_pkg::*;
#(
    parameter int DIV       = CLK_DIV,
    parameter int DEB_TICKS = counter_pkg::DEB_TICKS
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn,
    output logic Step
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(DEB_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(DEB_TICKS - 1);

    logic          sync_a;
    logic          btn_s;
    logic [PW-1:0] presc;
    logic          tick;
    deb_state_t    state;
    deb_state_t    state_n;
    logic [SW-1:0] stab;
    logic [SW-1:0] stab_n;
    logic          step_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_a <= Btn;
            btn_s  <= sync_a;
        end
    end

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            stab  <= '0;
            Step  <= 1'b0;
        end else begin
            state <= state_n;
            stab  <= stab_n;
            Step  <= step_n;
        end
    end

    // A qualifying tick that completes the stable run moves on immediately,
    // so stab never has to hold DEB_TICKS itself.
    always_comb begin
        state_n = state;
        stab_n  = stab;
        step_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = PRESS_WAIT;
                    stab_n  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    stab_n  = '0;
                end else if (tick) begin
                    if (stab == STAB_LAST) begin
                        state_n = PRESSED;
                        stab_n  = '0;
                        step_n  = 1'b1;
                    end else begin
                        stab_n = stab + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_n = REL_WAIT;
                    stab_n  = '0;
                end
            end
            REL_WAIT: begin
                if (btn_s) begin
                    state_n = PRESSED;
                    stab_n  = '0;
                end else if (tick) begin
                    if (stab == STAB_LAST) begin
                        state_n = IDLE;
                        stab_n  = '0;
                    end else begin
                        stab_n = stab + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                stab_n  = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_down_counter.sv
// Push-button down counter with parallel load, wrap/saturate at zero and zero flag.
// Button qualification lives in btn_debounce; this level only owns the count.
module btn_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = CNT_WIDTH,
    parameter int DIV       = CLK_DIV,
    parameter int DEB_TICKS = counter_pkg::DEB_TICKS,
    parameter int WRAP      = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Btn,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Count,
    output logic             Zero,
    output logic             Step
);

    logic [WIDTH-1:0] count_n;

    btn_debounce #(
        .DIV       (DIV),
        .DEB_TICKS (DEB_TICKS)
    ) u_debounce (
        .Clk   (Clk),
        .Reset (Reset),
        .Btn   (Btn),
        .Step  (Step)
    );

    // Load beats a coincident Step; that Step is simply dropped.
    always_comb begin
        count_n = Count;
        if (Load) begin
            count_n = LoadVal;
        end else if (Step) begin
            if ((WRAP != 0) || (Count != '0)) begin
                count_n = Count - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Count <= '1;
            Zero  <= 1'b0;
        end else begin
            Count <= count_n;
            Zero  <= (count_n == '0);
        end
    end

endmodule

// File: tb/tb_btn_down_counter.sv
// Bench for btn_down_counter: one wrapping and one saturating instance share stimulus;
// expected post-Step counts are queued up front and checked by an independent monitor.
module tb_btn_down_counter;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int DEB   = 3;

    typedef struct {
        logic [WIDTH-1:0] countWrap;
        logic             zeroWrap;
        logic [WIDTH-1:0] countSat;
        logic             zeroSat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             btn;
    logic             load;
    logic [WIDTH-1:0] loadVal;
    logic [WIDTH-1:0] countWrap, countSat;
    logic             zeroWrap, zeroSat;
    logic             stepWrap, stepSat;

    exp_t expQ[$];
    exp_t expCur;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   stepCount   = 0;
    int   lat;

    btn_down_counter #(.WIDTH(WIDTH), .DIV(DIV), .DEB_TICKS(DEB), .WRAP(1)) dutWrap (
        .Clk(clk), .Reset(reset), .Btn(btn), .Load(load), .LoadVal(loadVal),
        .Count(countWrap), .Zero(zeroWrap), .Step(stepWrap)
    );

    btn_down_counter #(.WIDTH(WIDTH), .DIV(DIV), .DEB_TICKS(DEB), .WRAP(0)) dutSat (
        .Clk(clk), .Reset(reset), .Btn(btn), .Load(load), .LoadVal(loadVal),
        .Count(countSat), .Zero(zeroSat), .Step(stepSat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic l, input logic [WIDTH-1:0] lv);
        btn     = b;
        load    = l;
        loadVal = lv;
    endtask

    task automatic checkBoth(input string name, input logic [WIDTH-1:0] cw, input logic zw,
                             input logic [WIDTH-1:0] cs, input logic zs);
        checkOutput({name, "_count_wrap"}, countWrap, cw);
        checkOutput({name, "_zero_wrap"}, zeroWrap, zw);
        checkOutput({name, "_count_sat"}, countSat, cs);
        checkOutput({name, "_zero_sat"}, zeroSat, zs);
    endtask

    // Button must already be driven high; returns negedges until Step is seen.
    task automatic waitForStep(output int latency);
        int found;
        found   = 0;
        latency = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (stepWrap) begin
                latency = i;
                found   = 1;
                break;
            end
        end
        checkOutput("step_seen_in_time", found, 1);
    endtask

    task automatic pressRelease(input int holdCycles);
        int l;
        applyStimulus(1'b1, 1'b0, '0);
        waitForStep(l);
        checkOutput("press_latency_in_window", (l >= 12 && l <= 15), 1);
        repeat (holdCycles) @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (40) @(negedge clk);
    endtask

    // Every Step must have a queued expectation; the count is checked one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (stepWrap || stepSat) begin
                stepCount++;
                checkOutput("step_agree", stepSat, stepWrap);
                checkOutput("step_expected", (expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    expCur = expQ.pop_front();
                    @(negedge clk);
                    checkOutput("mon_count_wrap", countWrap, expCur.countWrap);
                    checkOutput("mon_zero_wrap", zeroWrap, expCur.zeroWrap);
                    checkOutput("mon_count_sat", countSat, expCur.countSat);
                    checkOutput("mon_zero_sat", zeroSat, expCur.zeroSat);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkBoth("reset", 4'd15, 1'b0, 4'd15, 1'b0);
        checkOutput("reset_step", stepWrap, 0);
        repeat (100) @(negedge clk);
        checkOutput("idle_no_step", stepCount, 0);

        // Two clean presses: 15 -> 14 -> 13, one Step per long hold.
        expQ.push_back('{4'd14, 1'b0, 4'd14, 1'b0});
        pressRelease(200);
        checkOutput("held_single_step", stepCount, 1);
        expQ.push_back('{4'd13, 1'b0, 4'd13, 1'b0});
        pressRelease(30);
        checkBoth("after_two_presses", 4'd13, 1'b0, 4'd13, 1'b0);

        // Bounce with one-tick pulses must not qualify.
        applyStimulus(1'b1, 1'b0, '0); repeat (4) @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0); repeat (4) @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0); repeat (4) @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0); repeat (40) @(negedge clk);
        checkOutput("bounce_no_step", stepCount, 2);
        checkBoth("after_bounce", 4'd13, 1'b0, 4'd13, 1'b0);

        // Load 1 then underflow: wrap goes 0 -> 15, saturate sticks at 0.
        applyStimulus(1'b0, 1'b1, 4'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        checkBoth("load_one", 4'd1, 1'b0, 4'd1, 1'b0);
        expQ.push_back('{4'd0, 1'b1, 4'd0, 1'b1});
        pressRelease(30);
        expQ.push_back('{4'd15, 1'b0, 4'd0, 1'b1});
        pressRelease(30);
        checkBoth("after_underflow", 4'd15, 1'b0, 4'd0, 1'b1);

        // Load coinciding with Step: load wins, no late decrement.
        expQ.push_back('{4'd9, 1'b0, 4'd9, 1'b0});
        applyStimulus(1'b1, 1'b0, '0);
        waitForStep(lat);
        applyStimulus(1'b1, 1'b1, 4'd9);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0);
        checkBoth("load_vs_step", 4'd9, 1'b0, 4'd9, 1'b0);
        @(negedge clk);
        checkBoth("load_vs_step_hold", 4'd9, 1'b0, 4'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (40) @(negedge clk);

        // Reset during PRESS_WAIT with the button held: full requalification.
        applyStimulus(1'b1, 1'b0, '0);
        repeat (8) @(negedge clk);
        checkOutput("pre_reset_steps", stepCount, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkBoth("mid_press_reset", 4'd15, 1'b0, 4'd15, 1'b0);
        expQ.push_back('{4'd14, 1'b0, 4'd14, 1'b0});
        waitForStep(lat);
        checkOutput("requalify_latency", (lat >= 12 && lat <= 15), 1);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (40) @(negedge clk);
        checkBoth("after_requalify", 4'd14, 1'b0, 4'd14, 1'b0);

        checkOutput("total_steps", stepCount, 6);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
